// File: rtl/muldiv_unit.sv
// muldiv_unit: RV64M execute-stage multiply/divide sequencer.
// MUL/MULW are handed to an external multicycle multiplier over an en/done handshake.
// All divide/remainder ops run on an internal 64-step restoring divider.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   kill               pipeline flush, aborts the operation in flight
//   req_valid/ready    request handshake (ready only while idle)
//   req_op, req_a/b    decoded M-extension op and rs1/rs2 operands
//   resp_valid/data    one-cycle result pulse, registered result held until the next one
//   mul_en, mul_a/b    external multiplier enable and registered operands
//   mul_c, mul_done    external multiplier product (low 64 bits) and completion
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        kill,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic        mul_en,
  output logic [63:0] mul_a,
  output logic [63:0] mul_b,
  input  logic [63:0] mul_c,
  input  logic        mul_done
);

  typedef enum logic [2:0] {StIdle, StMulRun, StMulCap, StDivRun, StDivFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic        w_q, w_d;
  logic [63:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [63:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;
  logic [63:0] resp_data_q, resp_data_d;

  function automatic logic [63:0] sext32(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  function automatic logic is_rem_op(input logic [3:0] op);
    return (op == 4'd4) || (op == 4'd5) || (op == 4'd8) || (op == 4'd9);
  endfunction

  // Request decode and operand preparation.
  logic        req_w, req_uw, req_signed, req_ovf, sa, sb;
  logic [63:0] a_ext, b_ext, abs_a, abs_b, special_res, special_raw;

  assign req_w      = (req_op == 4'd1) || ((req_op >= 4'd6) && (req_op <= 4'd9));
  assign req_uw     = (req_op == 4'd7) || (req_op == 4'd9);
  assign req_signed = (req_op == 4'd2) || (req_op == 4'd4) || (req_op == 4'd6) ||
                      (req_op == 4'd8);
  assign a_ext = req_uw ? {32'd0, req_a[31:0]} : (req_w ? sext32(req_a) : req_a);
  assign b_ext = req_uw ? {32'd0, req_b[31:0]} : (req_w ? sext32(req_b) : req_b);
  assign sa    = req_signed & a_ext[63];
  assign sb    = req_signed & b_ext[63];
  assign abs_a = sa ? -a_ext : a_ext;
  assign abs_b = sb ? -b_ext : b_ext;
  // Only the 64-bit signed ops can overflow; the W forms fit after extension.
  assign req_ovf = ((req_op == 4'd2) || (req_op == 4'd4)) &&
                   (req_a == 64'h8000_0000_0000_0000) && (req_b == '1);
  assign special_raw = (b_ext == 64'd0) ? (is_rem_op(req_op) ? a_ext : '1)
                                        : (is_rem_op(req_op) ? 64'd0 : a_ext);
  assign special_res = req_w ? sext32(special_raw) : special_raw;

  // One restoring step; the shifted remainder needs a 65th bit for divisors >= 2^63.
  logic [64:0] rem_sh;
  logic        step_ge;
  assign rem_sh  = {rem_q, quo_q[63]};
  assign step_ge = rem_sh >= {1'b0, dvs_q};

  logic [63:0] q_fix, r_fix, fix_res;
  assign q_fix   = qneg_q ? -quo_q : quo_q;
  assign r_fix   = rneg_q ? -rem_q : rem_q;
  assign fix_res = is_rem_op(op_q) ? r_fix : q_fix;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    w_d         = w_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    resp_data_d = resp_data_q;
    case (state_q)
      StIdle: begin
        if (req_valid && !kill) begin
          op_d = req_op;
          w_d  = req_w;
          if (req_op <= 4'd1) begin
            mul_a_d = a_ext;
            mul_b_d = b_ext;
            state_d = StMulRun;
          end else if (req_op <= 4'd9) begin
            if ((b_ext == 64'd0) || req_ovf) begin
              resp_data_d = special_res;
              state_d     = StDone;
            end else begin
              rem_d   = 64'd0;
              quo_d   = abs_a;
              dvs_d   = abs_b;
              cnt_d   = 7'd64;
              qneg_d  = sa ^ sb;
              rneg_d  = sa;
              state_d = StDivRun;
            end
          end else begin
            resp_data_d = 64'd0;
            state_d     = StDone;
          end
        end
      end
      StMulRun: if (mul_done) state_d = StMulCap;
      StMulCap: begin
        resp_data_d = w_q ? sext32(mul_c) : mul_c;
        state_d     = StDone;
      end
      StDivRun: begin
        rem_d = step_ge ? (rem_sh[63:0] - dvs_q) : rem_sh[63:0];
        quo_d = {quo_q[62:0], step_ge};
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) state_d = StDivFix;
      end
      StDivFix: begin
        resp_data_d = w_q ? sext32(fix_res) : fix_res;
        state_d     = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Flush drops the op without touching the visible result.
    if (kill && (state_q != StIdle)) begin
      state_d     = StIdle;
      resp_data_d = resp_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= 4'd0;
      w_q         <= 1'b0;
      mul_a_q     <= 64'd0;
      mul_b_q     <= 64'd0;
      rem_q       <= 64'd0;
      quo_q       <= 64'd0;
      dvs_q       <= 64'd0;
      cnt_q       <= 7'd0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      resp_data_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      w_q         <= w_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StDone);
  assign mul_en     = (state_q == StMulRun);
  assign resp_data  = resp_data_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit with a behavioural multiplier model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, kill, req_valid, req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        mul_en;
  logic [63:0] mul_a, mul_b;
  logic [63:0] mul_c;
  logic        mul_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .kill      (kill),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .mul_en    (mul_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .mul_done  (mul_done)
  );

  // Multiplier model: done in the 4th cycle of mul_en, product valid only the cycle after.
  localparam int MulLat  = 3;
  localparam int MulResp = 6;
  localparam int DivResp = 66;
  int mcnt;
  always @(posedge clk) begin
    mul_c <= 64'hDEAD_BEEF_0BAD_F00D;
    if (reset) begin
      mcnt     <= 0;
      mul_done <= 1'b0;
    end else if (mul_done) begin
      mul_c    <= mul_a * mul_b;
      mul_done <= 1'b0;
      mcnt     <= 0;
    end else if (mul_en) begin
      if (mcnt == MulLat - 1) begin
        mul_done <= 1'b1;
        mcnt     <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op and check latency, pulse count and result.
  task automatic do_op(input string name, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat,
                       input bit is_mul);
    int first;
    int pulses;
    check({name, " ready"}, {63'd0, req_ready}, 64'd1);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    first = 0; pulses = 0;
    for (int c = 1; c <= lat + 3; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (is_mul && c == lat - 2) check({name, " mul_en run"}, {63'd0, mul_en}, 64'd1);
      if (is_mul && c == lat - 1) check({name, " mul_en cap"}, {63'd0, mul_en}, 64'd0);
    end
    check({name, " latency"}, 64'(first), 64'(lat));
    check({name, " pulses"}, 64'(pulses), 64'd1);
    check({name, " data"}, resp_data, exp);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    bit          is_mul;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs[NVec];

  initial begin
    int pulses;
    vecs[0]  = '{4'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, MulResp, 1'b1};
    vecs[1]  = '{4'd1, 64'h0000_0001_0001_0000, 64'h10000, 64'd0, MulResp, 1'b1};
    vecs[2]  = '{4'd1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MulResp, 1'b1};
    vecs[3]  = '{4'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, DivResp, 1'b0};
    vecs[4]  = '{4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, DivResp, 1'b0};
    vecs[5]  = '{4'd3, 64'd100, 64'd7, 64'd14, DivResp, 1'b0};
    vecs[6]  = '{4'd5, 64'd100, 64'd7, 64'd2, DivResp, 1'b0};
    vecs[7]  = '{4'd2, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0};
    vecs[8]  = '{4'd8, 64'h1_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1, 1'b0};
    vecs[9]  = '{4'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 1, 1'b0};
    vecs[10] = '{4'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1'b0};
    vecs[11] = '{4'd7, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, DivResp, 1'b0};
    vecs[12] = '{4'd6, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000,
                 DivResp, 1'b0};
    vecs[13] = '{4'd9, 64'h1_0000_0007, 64'd3, 64'd1, DivResp, 1'b0};
    vecs[14] = '{4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, DivResp, 1'b0};
    vecs[15] = '{4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                 64'h7FFF_FFFF_FFFF_FFFE, DivResp, 1'b0};
    vecs[16] = '{4'd12, 64'd5, 64'd3, 64'd0, 1, 1'b0};

    reset = 1'b1; kill = 1'b0; req_valid = 1'b0;
    req_op = 4'd0; req_a = 64'd0; req_b = 64'd0;
    repeat (3) @(negedge clk);
    check("rst ready", {63'd0, req_ready}, 64'd1);
    check("rst resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst resp_data", resp_data, 64'd0);
    check("rst mul_en", {63'd0, mul_en}, 64'd0);
    check("rst mul_a", mul_a, 64'd0);
    check("rst mul_b", mul_b, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVec; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
            vecs[i].lat, vecs[i].is_mul);
    end

    // kill while idle must block acceptance
    req_op = 4'd3; req_a = 64'd100; req_b = 64'd7; req_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    check("idle kill ready", {63'd0, req_ready}, 64'd1);

    do_op("pre-kill", 4'd3, 64'd100, 64'd7, 64'd14, DivResp, 1'b0);

    // kill in cycle 30 of a divide
    req_op = 4'd2; req_a = 64'd999; req_b = 64'd3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
      if (c == 30) begin
        check("kill busy", {63'd0, req_ready}, 64'd0);
        kill = 1'b1;
      end
      if (c == 31) begin
        kill = 1'b0;
        check("kill idle", {63'd0, req_ready}, 64'd1);
      end
    end
    check("kill pulses", 64'(pulses), 64'd0);
    check("kill data", resp_data, 64'd14);

    // reset in the middle of a multiply
    req_op = 4'd0; req_a = 64'd5; req_b = 64'd6; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid mul_en", {63'd0, mul_en}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mrst ready", {63'd0, req_ready}, 64'd1);
    check("mrst resp_valid", {63'd0, resp_valid}, 64'd0);
    check("mrst resp_data", resp_data, 64'd0);
    check("mrst mul_en", {63'd0, mul_en}, 64'd0);
    check("mrst mul_a", mul_a, 64'd0);
    check("mrst mul_b", mul_b, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op("post-rst div", 4'd3, 64'd100, 64'd7, 64'd14, DivResp, 1'b0);
    do_op("post-rst mul", 4'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB,
          MulResp, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Execute-stage multiply/divide sequencer for RV64M. Accepts one decoded M-extension operation at a time from the execute stage and prepares operands. MUL/MULW are driven into the external multicycle multiplier over its en/done contract; all divide/remainder ops run on an internal 64-iteration restoring divider. Returns one word-extended 64-bit result with a one-cycle valid pulse while the pipeline stalls on `req_ready`.

## Interface
- No parameters.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `kill`  in  1  pipeline flush; aborts any operation in flight.
- `req_valid`  in  1  operation request.
- `req_ready`  out  1  high only in IDLE; request accepted when `req_valid & req_ready`.
- `req_op`  in  4  0 MUL, 1 MULW, 2 DIV, 3 DIVU, 4 REM, 5 REMU, 6 DIVW, 7 DIVUW, 8 REMW, 9 REMUW; 10–15 illegal.
- `req_a`, `req_b`  in  64  rs1/rs2 operands.
- `resp_valid`  out  1  one-cycle pulse; result available.
- `resp_data`  out  64  result; registered, held until next result.
- `mul_en`  out  1  multiplier enable.
- `mul_a`, `mul_b`  out  64  multiplier operands, registered, stable while `mul_en`.
- `mul_c`  in  64  multiplier product, low 64 bits.
- `mul_done`  in  1  multiplier completion.

## Operation
- States: IDLE, MUL_RUN, MUL_CAP, DIV_RUN, DIV_FIX, DONE.
- Reset: state IDLE; `req_ready`=1; `resp_valid`=0; `resp_data`=0; `mul_en`=0; `mul_a`/`mul_b`=0; divider registers 0.
- Operand latch on accept: W ops sign-extend low 32 bits of a/b; DIVUW/REMUW zero-extend. Latch op and a W flag.
- IDLE → MUL_RUN for ops 0/1. `mul_en`=1 throughout MUL_RUN.
- MUL_RUN → MUL_CAP when `mul_done`=1 with `mul_en`=1.
- Multiplier contract: `mul_c` is valid only in the single cycle after that cycle.
- MUL_CAP: `mul_en`=0; latch `mul_c` (W: sign-extend bit 31) into `resp_data`; → DONE.
- IDLE → DIV_RUN for ops 2–9 when divisor ≠ 0 and not signed overflow. Latch |a| and |b| (signed ops) or raw values (unsigned). Record quotient sign = sa^sb and remainder sign = sa. Iteration count = 64.
- DIV_RUN: one restoring step per cycle:
  - rem = {rem[62:0], q[63]}, q <<= 1.
  - If rem ≥ divisor: rem -= divisor, q[0]=1.
  - After 64th step → DIV_FIX.
- DIV_FIX: negate q/rem per recorded signs. Select quotient (DIV*) or remainder (REM*). W: sign-extend bit 31 into `resp_data`. → DONE.
- Special cases skip DIV_RUN, IDLE → DONE directly, `resp_data` written at accept:
  - divisor = 0: quotient all ones, remainder = extended dividend.
  - signed 64-bit overflow (a=0x8000…0, b=all ones, op DIV/REM only): quotient = a, remainder 0.
  - W results are then sign-extended from bit 31.
- Illegal op: IDLE → DONE with `resp_data`=0.
- DONE: `resp_valid`=1 one cycle; `req_ready`=0; → IDLE.
- `kill` (any state except IDLE): → IDLE next edge, `mul_en`=0 that edge onward, no `resp_valid`, `resp_data` unchanged. `kill` in IDLE blocks acceptance that cycle. `kill` in DONE suppresses nothing already pulsed; state still → IDLE.
- `reset` overrides `kill` and any state.

## Timing
- Accept at edge 0; new state from cycle 1.
- DIV family (normal): DIV_RUN cycles 1–64, DIV_FIX cycle 65, `resp_valid` cycle 66. Back-to-back accept possible at cycle 67.
- Special/illegal: `resp_valid` in cycle 1.
- MUL: `mul_en` high from cycle 1 until `mul_done` cycle N; MUL_CAP in cycle N+1; `resp_valid` in cycle N+2.
- `req_ready` is combinational from state only; no dependence on `req_valid`.

## Test plan
- MUL a=−3, b=7 → `resp_data`=0xFFFF_FFFF_FFFF_FFEB; `mul_en` deasserted in MUL_CAP; exactly one `resp_valid`.
- MULW a=0x0000_0001_0001_0000, b=0x10000 → low32 = 0 → `resp_data`=0. Then a=0x7FFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFE.
- DIV −7/2 → −3; REM −7/2 → −1; DIVU 100/7 → 14; REMU → 2. `resp_valid` exactly at cycle 66.
- DIV by 0 → all ones; REMW a=0x1_8000_0000, b=0 → 0xFFFF_FFFF_8000_0000; DIV 0x8000…0/−1 → 0x8000…0, REM → 0. All in cycle 1.
- DIVUW a=0xFFFF_FFFF, b=1 → 0xFFFF_FFFF_FFFF_FFFF; DIVW a=0x8000_0000, b=−1 → 0xFFFF_FFFF_8000_0000.
- `kill` at cycle 30 of DIV → IDLE cycle 31, no `resp_valid`. `reset` mid-MUL → all outputs at reset values next cycle. New request then completes correctly.
